// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder: RV32I size codes,
// FSM state type and the size/alignment legality check.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Size/alignment/encoding error; the address range check lives in the top
  // because it depends on DEPTH_WORDS.
  function automatic logic access_err(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] lane);
    logic err;
    case (f3)
      F3_B:    err = 1'b0;
      F3_H:    err = lane[0];
      F3_W:    err = (lane != 2'b00);
      F3_BU:   err = wr;
      F3_HU:   err = wr | lane[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/data_mem_responder_align.sv
// Lane extraction with sign/zero extension for loads and byte-lane merge for
// stores; purely combinational.
module data_mem_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] wword
);

  logic [15:0] lane_data;
  logic [31:0] wdata_sh;
  logic [3:0]  be;

  always_comb begin
    lane_data = 16'(word >> {lane, 3'b000});
    case (funct3)
      F3_B:    rdata = {{24{lane_data[7]}}, lane_data[7:0]};
      F3_H:    rdata = {{16{lane_data[15]}}, lane_data};
      F3_W:    rdata = word;
      F3_BU:   rdata = {24'd0, lane_data[7:0]};
      F3_HU:   rdata = {16'd0, lane_data};
      default: rdata = 32'd0;
    endcase
  end

  // Right-aligned store data is moved up to the addressed lane, then merged
  // under a byte enable so untouched lanes keep the old word.
  always_comb begin
    wdata_sh = wdata << {lane, 3'b000};
    case (funct3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = 4'b0011 << lane;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      wword[i*8 +: 8] = be[i] ? wdata_sh[i*8 +: 8] : word[i*8 +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder in front of a DEPTH_WORDS x 32
// storage array, with WAIT_CYCLES wait states between accept and response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cap_write_q, cap_write_d;
  logic [2:0]  cap_funct3_q, cap_funct3_d;
  logic [31:0] cap_addr_q, cap_addr_d;
  logic [31:0] cap_wdata_q, cap_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic             acc_write;
  logic [2:0]       acc_funct3;
  logic [31:0]      acc_addr, acc_wdata;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_err;
  logic             enter_resp;
  logic             mem_we;
  logic [31:0]      cur_word, ld_data, st_word;

  assign req_ready = (state_q == ST_IDLE) && rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // access uses the live request; otherwise it uses the captured copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write  = req_write;
      acc_funct3 = req_funct3;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_write  = cap_write_q;
      acc_funct3 = cap_funct3_q;
      acc_addr   = cap_addr_q;
      acc_wdata  = cap_wdata_q;
    end
    acc_idx  = acc_addr[IDX_W+1:2];
    cur_word = mem[acc_idx];
    acc_err  = ((acc_addr >> (IDX_W + 2)) != 32'd0) ||
               access_err(acc_write, acc_funct3, acc_addr[1:0]);
  end

  data_mem_align u_align (
    .funct3 (acc_funct3),
    .lane   (acc_addr[1:0]),
    .word   (cur_word),
    .wdata  (acc_wdata),
    .rdata  (ld_data),
    .wword  (st_word)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_write_d  = cap_write_q;
    cap_funct3_d = cap_funct3_q;
    cap_addr_d   = cap_addr_q;
    cap_wdata_d  = cap_wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    enter_resp   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          cap_write_d  = req_write;
          cap_funct3_d = req_funct3;
          cap_addr_d   = req_addr;
          cap_wdata_d  = req_wdata;
          cnt_d        = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
          state_d    = ST_RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? 32'd0 : ld_data;
    end
    mem_we = enter_resp && acc_write && !acc_err && rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      cap_write_q  <= 1'b0;
      cap_funct3_q <= 3'd0;
      cap_addr_q   <= 32'd0;
      cap_wdata_q  <= 32'd0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_write_q  <= cap_write_d;
      cap_funct3_q <= cap_funct3_d;
      cap_addr_q   <= cap_addr_d;
      cap_wdata_q  <= cap_wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= st_word;
  end

endmodule
